// File: rtl/regfile_write_arbiter_pkg.sv
// Purpose : shared widths, register-file constants and grant encoding for the writeback arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package regfile_write_arbiter_pkg;

  // Default register-file geometry: 32 registers of 32 bits.
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int NUM_REGS  = 1 << RF_ADDR_W;

  // Register 0 is hard-wired to zero: writes to it are dropped and it is never pending.
  localparam logic [RF_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Default number of refusals B tolerates before it is promoted over A.
  localparam int DEF_MAX_WAIT = 4;

  // Winner of the shared write port in a given cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Purpose : bundles both writeback requesters, the issue-time mark, decode read ports and the RF write port.
// Latency : n/a (wires only).
// Backpressure: a_ready/b_ready are the only stall signals; the RF write port never stalls.
interface regfile_write_arbiter_if
  import regfile_write_arbiter_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
);

  // Source A: in-order pipeline writeback stage.
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;

  // Source B: multi-cycle unit (mul/div) writeback.
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;

  // Issue of a B operation: its destination becomes pending.
  logic              mark_valid;
  logic [ADDR_W-1:0] mark_addr;

  // Decode source registers and their hazard flags.
  logic [ADDR_W-1:0] read1;
  logic [ADDR_W-1:0] read2;
  logic              hazard1;
  logic              hazard2;

  // Register-file write port.
  logic              RegWrite;
  logic [ADDR_W-1:0] write;
  logic [DATA_W-1:0] writeData;

  // Arbiter side.
  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    input  mark_valid, mark_addr,
    input  read1, read2,
    output a_ready, b_ready,
    output hazard1, hazard2,
    output RegWrite, write, writeData
  );

  // Requester / pipeline side.
  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    output mark_valid, mark_addr,
    output read1, read2,
    input  a_ready, b_ready,
    input  hazard1, hazard2,
    input  RegWrite, write, writeData
  );

endinterface

// File: rtl/regfile_write_arbiter_rf_scoreboard.sv
// Purpose : one pending bit per register for outstanding B results, with two combinational lookups.
// Latency : set/clear visible on hit1/hit2 the cycle after the edge; lookups are combinational.
// Backpressure: none; set and clear are accepted every cycle.
module regfile_write_arbiter_rf_scoreboard
  import regfile_write_arbiter_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_vld,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_vld,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic              hit1,
  output logic              hit2
);

  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;

  // Decode set/clear into one-hot masks; register 0 can never become pending.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_vld) begin
      set_mask[set_addr] = 1'b1;
    end
    if (clr_vld) begin
      clr_mask[clr_addr] = 1'b1;
    end
    set_mask[0] = 1'b0;
  end

  // Clear first, then set, so a new issue to a register that is retiring
  // in the same cycle stays pending for the new operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~clr_mask) | set_mask;
    end
  end

  // No bypass: a result retiring this cycle still reports a hazard until the edge.
  assign hit1 = pend[rd1_addr];
  assign hit2 = pend[rd2_addr];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Purpose : shares the single register-file write port between pipeline WB (A) and the mul/div unit (B).
// Latency : 1 cycle from accepted request to RegWrite/write/writeData.
// Backpressure: A has fixed priority; B is promoted after MAX_WAIT consecutive refusals. RF port never stalls.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
)(
  input  logic                   clk,
  input  logic                   rst,
  regfile_write_arbiter_if.slave bus
);

  // Counter only needs to reach MAX_WAIT, where it saturates.
  localparam int              CW      = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_WAIT);

  // Registered register-file write.
  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_t;

  logic [CW-1:0]     wait_cnt;
  logic              starve;
  grant_t            gnt;
  logic              xfer;
  logic              b_xfer;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  wb_t               wb_q;

  assign starve = (wait_cnt >= MAX_CNT);

  // Fixed priority to A unless B has been refused long enough to be starving.
  always_comb begin
    gnt = GNT_NONE;
    if (starve && bus.b_valid) begin
      gnt = GNT_B;
    end else if (bus.a_valid) begin
      gnt = GNT_A;
    end else if (bus.b_valid) begin
      gnt = GNT_B;
    end
  end

  assign bus.a_ready = (gnt == GNT_A);
  assign bus.b_ready = (gnt == GNT_B);

  // The ready already implies the matching valid, so any grant is a transfer.
  assign xfer   = (gnt != GNT_NONE);
  assign b_xfer = (gnt == GNT_B);

  // Select the winner's payload for the output register.
  always_comb begin
    win_addr = bus.a_addr;
    win_data = bus.a_data;
    if (gnt == GNT_B) begin
      win_addr = bus.b_addr;
      win_data = bus.b_data;
    end
  end

  // Count consecutive refusals of B; any B grant or idle B restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (bus.b_valid && !bus.b_ready) begin
      if (!starve) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  // Output stage: register the winning write; writes to r0 complete the
  // handshake but never raise the enable. Address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q <= '0;
    end else begin
      wb_q.vld <= xfer && (win_addr != '0);
      if (xfer) begin
        wb_q.addr <= win_addr;
        wb_q.data <= win_data;
      end
    end
  end

  assign bus.RegWrite  = wb_q.vld;
  assign bus.write     = wb_q.addr;
  assign bus.writeData = wb_q.data;

  // Pending-write tracking for decode hazard detection; only B results are tracked.
  regfile_write_arbiter_rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_vld  (bus.mark_valid),
    .set_addr (bus.mark_addr),
    .clr_vld  (b_xfer),
    .clr_addr (bus.b_addr),
    .rd1_addr (bus.read1),
    .rd2_addr (bus.read2),
    .hit1     (bus.hazard1),
    .hit2     (bus.hazard2)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Purpose : directed and randomised stimulus for the writeback arbiter, checked against a behavioural model.
// Latency : model expects RF write one cycle after the accepted request.
// Backpressure: model recomputes grants from the priority and starvation rules every cycle.
module tb_regfile_write_arbiter;

  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_write_arbiter #(
    .ADDR_W   (5),
    .DATA_W   (32),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_refused = 0;   // consecutive cycles B was refused
  logic [31:0] m_pend    = '0;  // registers awaiting a B result
  logic        m_rw      = 1'b0;
  logic [4:0]  m_wa      = '0;
  logic [31:0] m_wd      = '0;

  // 0 = nobody, 1 = A, 2 = B
  function automatic int model_grant();
    if (m_refused >= MAX_WAIT && bus.b_valid) return 2;
    if (bus.a_valid) return 1;
    if (bus.b_valid) return 2;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    int g;
    if (rst) begin
      m_refused = 0;
      m_pend    = '0;
      m_rw      = 1'b0;
      m_wa      = '0;
      m_wd      = '0;
    end else begin
      g = model_grant();
      if (bus.b_valid && g != 2) m_refused = (m_refused + 1 > MAX_WAIT) ? MAX_WAIT : m_refused + 1;
      else m_refused = 0;
      if (g == 2) m_pend[bus.b_addr] = 1'b0;
      if (bus.mark_valid && bus.mark_addr != 5'd0) m_pend[bus.mark_addr] = 1'b1;
      if (g == 1) begin
        m_wa = bus.a_addr; m_wd = bus.a_data; m_rw = (bus.a_addr != 5'd0);
      end else if (g == 2) begin
        m_wa = bus.b_addr; m_wd = bus.b_data; m_rw = (bus.b_addr != 5'd0);
      end else begin
        m_rw = 1'b0;
      end
    end
  end

  // Compare every cycle away from the active edge.
  always @(negedge clk) begin
    int g;
    if (cmp_en) begin
      g = model_grant();
      check("a_ready", 64'(bus.a_ready), 64'(g == 1));
      check("b_ready", 64'(bus.b_ready), 64'(g == 2));
      check("hazard1", 64'(bus.hazard1), 64'(m_pend[bus.read1]));
      check("hazard2", 64'(bus.hazard2), 64'(m_pend[bus.read2]));
      check("RegWrite", 64'(bus.RegWrite), 64'(m_rw));
      if (m_rw) begin
        check("write", 64'(bus.write), 64'(m_wa));
        check("writeData", 64'(bus.writeData), 64'(m_wd));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    bus.mark_valid = 1'b0; bus.mark_addr = '0;
    bus.read1 = '0; bus.read2 = '0;
  endtask

  initial begin
    string exp_pat;
    byte   got;
    exp_pat = "AAAABAAAAB";
    idle_inputs();
    #1 rst = 1'b1;
    #2;
    check("reset RegWrite", 64'(bus.RegWrite), 64'd0);
    check("reset write", 64'(bus.write), 64'd0);
    check("reset writeData", 64'(bus.writeData), 64'd0);
    check("reset a_ready", 64'(bus.a_ready), 64'd0);
    check("reset b_ready", 64'(bus.b_ready), 64'd0);
    check("reset hazard1", 64'(bus.hazard1), 64'd0);
    @(negedge clk); #1 rst = 1'b0;
    cmp_en = 1'b1;
    step();

    // A only: r3 <= 3
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'h3;
    #1 check("A only a_ready", 64'(bus.a_ready), 64'd1);
    step();
    idle_inputs();
    #1;
    check("A only RegWrite", 64'(bus.RegWrite), 64'd1);
    check("A only write", 64'(bus.write), 64'd3);
    check("A only writeData", 64'(bus.writeData), 64'h3);
    step();
    check("A only RegWrite drop", 64'(bus.RegWrite), 64'd0);
    check("A only write hold", 64'(bus.write), 64'd3);

    // Contention: both valid for ten cycles
    bus.a_valid = 1'b1; bus.a_addr = 5'd10;
    bus.b_valid = 1'b1; bus.b_addr = 5'd11;
    for (int i = 0; i < 10; i++) begin
      bus.a_data = 32'(i + 1);
      bus.b_data = 32'h100 + 32'(i);
      #1;
      got = bus.a_ready ? 8'h41 : (bus.b_ready ? 8'h42 : 8'h2d);
      check($sformatf("contention grant %0d", i), 64'(got), 64'(exp_pat[i]));
      step();
    end
    idle_inputs();
    step();

    // r0: B writes r0 and marks r0 -> handshake only, no write, no hazard
    bus.b_valid = 1'b1; bus.b_addr = 5'd0; bus.b_data = 32'h5;
    bus.mark_valid = 1'b1; bus.mark_addr = 5'd0;
    #1 check("r0 b_ready", 64'(bus.b_ready), 64'd1);
    step();
    idle_inputs();
    #1;
    check("r0 RegWrite", 64'(bus.RegWrite), 64'd0);
    check("r0 hazard1", 64'(bus.hazard1), 64'd0);

    // Scoreboard: mark r5, then B retires r5
    bus.mark_valid = 1'b1; bus.mark_addr = 5'd5;
    step();
    bus.mark_valid = 1'b0; bus.read1 = 5'd5;
    #1 check("r5 pending", 64'(bus.hazard1), 64'd1);
    bus.b_valid = 1'b1; bus.b_addr = 5'd5; bus.b_data = 32'h55;
    #1;
    check("r5 b_ready", 64'(bus.b_ready), 64'd1);
    check("r5 hazard before edge", 64'(bus.hazard1), 64'd1);
    step();
    bus.b_valid = 1'b0;
    #1;
    check("r5 cleared", 64'(bus.hazard1), 64'd0);
    check("r5 RegWrite", 64'(bus.RegWrite), 64'd1);
    check("r5 write", 64'(bus.write), 64'd5);
    check("r5 writeData", 64'(bus.writeData), 64'h55);

    // Same-edge set and clear on r7: set wins
    idle_inputs();
    bus.mark_valid = 1'b1; bus.mark_addr = 5'd7; bus.read2 = 5'd7;
    step();
    bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 32'h77;
    #1 check("r7 b_ready", 64'(bus.b_ready), 64'd1);
    step();
    bus.mark_valid = 1'b0; bus.b_valid = 1'b0;
    #1 check("r7 set wins", 64'(bus.hazard2), 64'd1);
    bus.b_valid = 1'b1;
    step();
    bus.b_valid = 1'b0;
    #1 check("r7 second retire", 64'(bus.hazard2), 64'd0);

    // Randomised soak, checked by the model every cycle
    for (int i = 0; i < 400; i++) begin
      bus.a_valid    = 1'($urandom_range(0, 1));
      bus.a_addr     = 5'($urandom_range(0, 7));
      bus.a_data     = $urandom;
      bus.b_valid    = 1'($urandom_range(0, 3) != 0);
      bus.b_addr     = 5'($urandom_range(0, 7));
      bus.b_data     = $urandom;
      bus.mark_valid = 1'($urandom_range(0, 1));
      bus.mark_addr  = 5'($urandom_range(0, 7));
      bus.read1      = 5'($urandom_range(0, 7));
      bus.read2      = 5'($urandom_range(0, 7));
      step();
    end
    idle_inputs();
    step();

    // Mid-run reset with a write in flight and r9 pending
    bus.mark_valid = 1'b1; bus.mark_addr = 5'd9;
    step();
    bus.mark_valid = 1'b0; bus.read1 = 5'd9;
    bus.a_valid = 1'b1; bus.a_addr = 5'd9; bus.a_data = 32'h99;
    step();
    bus.a_valid = 1'b0;
    #1;
    check("pre-reset RegWrite", 64'(bus.RegWrite), 64'd1);
    check("pre-reset hazard1", 64'(bus.hazard1), 64'd1);
    rst = 1'b1;
    #1;
    check("mid reset RegWrite", 64'(bus.RegWrite), 64'd0);
    check("mid reset write", 64'(bus.write), 64'd0);
    check("mid reset writeData", 64'(bus.writeData), 64'd0);
    check("mid reset hazard1", 64'(bus.hazard1), 64'd0);
    @(negedge clk); #1 rst = 1'b0;
    step();
    check("post reset RegWrite", 64'(bus.RegWrite), 64'd0);
    check("post reset hazard1", 64'(bus.hazard1), 64'd0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
